// File: rtl/disparo_pkg.sv
// Shared types for the fire-control path: FSM state codes and debug/counter widths.
// The state codes are visible on db_estado and must stay fixed.
package disparo_pkg;

    localparam int DB_W    = 4;
    localparam int TIROS_W = 3;

    typedef enum logic [DB_W-1:0] {
        INICIAL  = 4'd0,
        ESPERA   = 4'd1,
        REGISTRA = 4'd2,
        COOLDOWN = 4'd3
    } estado_t;

endpackage

// File: rtl/sincroniza_borda.sv
// Two-flop synchroniser for an asynchronous input followed by a rising-edge detector.
// Latency: level valid 2 edges after first sample; edge pulse lasts one cycle. No backpressure.
module sincroniza_borda (
    input  logic clock,
    input  logic reset,
    input  logic entrada,
    output logic nivel,
    output logic borda
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic ant_q, ant_d;

    always_comb begin
        s1_d  = entrada;
        s2_d  = s1_q;
        ant_d = s2_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            ant_q <= 1'b0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            ant_q <= ant_d;
        end
    end

    assign nivel = s2_q;
    assign borda = s2_q & ~ant_q;

endmodule

// File: rtl/controle_disparo.sv
// Fire control: button -> single held registra_tiro request, cooldown, on-screen shot count.
// Latency: request 2 edges after first button sample; held until tiro_registrado. Optional DISPARO_AUTO_EN = autofire.
module controle_disparo
    import disparo_pkg::*;
#(
    parameter int COOLDOWN_CICLOS = 8,
    parameter int MAX_TIROS       = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               botao_tiro,
    input  logic               jogo_ativo,
    input  logic               tiro_registrado,
    input  logic               tiro_liberado,
    output logic               registra_tiro,
    output logic [TIROS_W-1:0] tiros_ativos,
    output logic               pronto,
    output logic [DB_W-1:0]    db_estado
);

    localparam int                 CW    = $clog2(COOLDOWN_CICLOS + 1);
    localparam logic [CW-1:0]      CARGA = CW'(COOLDOWN_CICLOS);
    localparam logic [TIROS_W-1:0] MAX   = TIROS_W'(MAX_TIROS);
`ifdef DISPARO_AUTO_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic               nivel, borda, aceita, tem_vaga, ack_ok;
    estado_t            estado_q, estado_d;
    logic [CW-1:0]      cont_q, cont_d;
    logic [TIROS_W-1:0] tiros_q, tiros_d;

    sincroniza_borda u_sinc (
        .clock   (clock),
        .reset   (reset),
        .entrada (botao_tiro),
        .nivel   (nivel),
        .borda   (borda)
    );

    // With autofire a held (synchronised) button counts as a fresh press.
    assign aceita   = borda | (AUTO & nivel);
    assign tem_vaga = (tiros_q < MAX);

    always_comb begin
        estado_d = estado_q;
        cont_d   = cont_q;
        tiros_d  = tiros_q;
        ack_ok   = 1'b0;
        case (estado_q)
            INICIAL: if (jogo_ativo) estado_d = ESPERA;
            ESPERA: begin
                if (!jogo_ativo)             estado_d = INICIAL;
                else if (aceita && tem_vaga) estado_d = REGISTRA;
            end
            REGISTRA: begin
                if (tiro_registrado) begin
                    ack_ok   = 1'b1;
                    estado_d = COOLDOWN;
                    cont_d   = CARGA;
                end
            end
            COOLDOWN: begin
                if (!jogo_ativo) begin
                    estado_d = INICIAL;
                    cont_d   = '0;
                end else if (cont_q <= CW'(1)) begin
                    estado_d = ESPERA;
                    cont_d   = '0;
                end else begin
                    cont_d = cont_q - CW'(1);
                end
            end
            default: estado_d = INICIAL;
        endcase

        // Simultaneous ack and release cancel out.
        if (ack_ok && !tiro_liberado) begin
            if (tiros_q < MAX) tiros_d = tiros_q + TIROS_W'(1);
        end else if (!ack_ok && tiro_liberado && tiros_q != '0) begin
            tiros_d = tiros_q - TIROS_W'(1);
        end
        if (estado_d == INICIAL) tiros_d = '0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= INICIAL;
            cont_q   <= '0;
            tiros_q  <= '0;
        end else begin
            estado_q <= estado_d;
            cont_q   <= cont_d;
            tiros_q  <= tiros_d;
        end
    end

    assign registra_tiro = (estado_q == REGISTRA);
    assign pronto        = (estado_q == ESPERA) && jogo_ativo && tem_vaga;
    assign tiros_ativos  = tiros_q;
    assign db_estado     = estado_q;

endmodule

// File: tb/tb_controle_disparo.sv
// Bench for controle_disparo: directed scenarios plus a random fire/release phase,
// checked against a transaction-level model of the shot count and request timing.
module tb_controle_disparo;

    localparam int CD   = 8;
    localparam int MAXT = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       botao_tiro = 1'b0;
    logic       jogo_ativo = 1'b0;
    logic       tiro_registrado = 1'b0;
    logic       tiro_liberado = 1'b0;
    logic       registra_tiro;
    logic [2:0] tiros_ativos;
    logic       pronto;
    logic [3:0] db_estado;

    int vectors = 0;
    int miscompares = 0;
    int m_tiros = 0;

    controle_disparo #(.COOLDOWN_CICLOS(CD), .MAX_TIROS(MAXT)) dut (
        .clock           (clock),
        .reset           (reset),
        .botao_tiro      (botao_tiro),
        .jogo_ativo      (jogo_ativo),
        .tiro_registrado (tiro_registrado),
        .tiro_liberado   (tiro_liberado),
        .registra_tiro   (registra_tiro),
        .tiros_ativos    (tiros_ativos),
        .pronto          (pronto),
        .db_estado       (db_estado)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic liberar();
        tiro_liberado = 1'b1;
        tick();
        tiro_liberado = 1'b0;
        if (m_tiros > 0) m_tiros--;
        chk("tiros_after_release", tiros_ativos, m_tiros);
        chk("pronto_after_release", pronto, m_tiros < MAXT);
    endtask

    // One press from ESPERA; d = ack delay, lib = release coincident with ack,
    // press_cd = also press during the following cooldown.
    task automatic fire(input int d, input bit lib, input bit press_cd);
        int n;
        bit seen, exp_req, extra;
        exp_req = (m_tiros < MAXT);
        botao_tiro = 1'b1;
        n = 0;
        while (!registra_tiro && n < 12) begin tick(); n++; end
        seen = registra_tiro;
        botao_tiro = 1'b0;
        chk("req_issued", seen, exp_req);
        if (seen) begin
            chk("req_latency", n, 3);
            for (int i = 0; i < d; i++) begin
                tick();
                chk("req_hold", registra_tiro, 1);
            end
            tiro_registrado = 1'b1;
            tiro_liberado   = lib;
            tick();
            tiro_registrado = 1'b0;
            tiro_liberado   = 1'b0;
            if (!lib && m_tiros < MAXT) m_tiros++;
            chk("req_drop", registra_tiro, 0);
            chk("state_cooldown", db_estado, 3);
            chk("tiros_after_ack", tiros_ativos, m_tiros);
            n = 1;
            while (db_estado == 4'd3 && n < 40) begin
                if (n == 2) botao_tiro = press_cd;
                if (n == 5) botao_tiro = 1'b0;
                tick();
                n++;
            end
            botao_tiro = 1'b0;
            chk("cooldown_len", n - 1, CD);
            chk("state_espera", db_estado, 1);
            chk("pronto_after_cd", pronto, m_tiros < MAXT);
            if (press_cd) begin
                extra = 1'b0;
                for (int i = 0; i < 10; i++) begin
                    tick();
                    if (registra_tiro) extra = 1'b1;
                end
                chk("press_in_cd_dropped", extra, 0);
                chk("tiros_unchanged_cd", tiros_ativos, m_tiros);
            end
        end else begin
            repeat (3) tick();
            chk("ignored_state", db_estado, 1);
            chk("ignored_tiros", tiros_ativos, m_tiros);
        end
    endtask

    initial begin
        int n, rises, last_rise, gap_bad;
        bit prev;

        // Reset state
        #1;
        chk("rst_registra", registra_tiro, 0);
        chk("rst_tiros", tiros_ativos, 0);
        chk("rst_pronto", pronto, 0);
        chk("rst_db", db_estado, 0);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        chk("idle_db", db_estado, 0);
        jogo_ativo = 1'b1;
        tick();
        chk("espera_db", db_estado, 1);
        chk("espera_pronto", pronto, 1);

        // 5-cycle press, ack two cycles after request
        botao_tiro = 1'b1;
        tick(); tick();
        chk("t1_no_req_k1", registra_tiro, 0);
        tick();
        chk("t1_req_k2", registra_tiro, 1);
        chk("t1_db_reg", db_estado, 2);
        tick(); chk("t1_req_k3", registra_tiro, 1);
        tick(); chk("t1_req_k4", registra_tiro, 1);
        botao_tiro = 1'b0;
        tiro_registrado = 1'b1;
        tick();
        tiro_registrado = 1'b0;
        m_tiros = 1;
        chk("t1_req_fall", registra_tiro, 0);
        chk("t1_db_cd", db_estado, 3);
        chk("t1_tiros", tiros_ativos, 1);
        n = 1;
        while (db_estado == 4'd3 && n < 40) begin tick(); n++; end
        chk("t1_cd_len", n - 1, CD);
        chk("t1_db_back", db_estado, 1);
        chk("t1_pronto", pronto, 1);

        // Fill to capacity, fifth press ignored, release frees one slot
        liberar();
        for (int i = 0; i < 5; i++) fire($urandom_range(0, 3), 1'b0, 1'b0);
        chk("full_pronto", pronto, 0);
        chk("full_tiros", tiros_ativos, 4);
        liberar();
        fire($urandom_range(0, 3), 1'b0, 1'b0);
        chk("refill_tiros", tiros_ativos, 4);

        // Press during cooldown is discarded
        liberar();
        liberar();
        fire($urandom_range(0, 3), 1'b0, 1'b1);

        // Release coincident with ack; release at zero
        liberar();
        chk("pre_coinc", tiros_ativos, 2);
        fire($urandom_range(0, 3), 1'b1, 1'b0);
        chk("coinc_tiros", tiros_ativos, 2);
        liberar();
        liberar();
        liberar();
        chk("zero_floor", tiros_ativos, 0);

        // Random fire/release mix
        for (int i = 0; i < 14; i++) begin
            if ($urandom_range(0, 2) != 0) fire($urandom_range(0, 3), 1'b0, 1'b0);
            else liberar();
        end

        // jogo_ativo dropped while a request is open
        if (m_tiros == MAXT) liberar();
        botao_tiro = 1'b1;
        n = 0;
        while (!registra_tiro && n < 12) begin tick(); n++; end
        botao_tiro = 1'b0;
        chk("drop_req_seen", registra_tiro, 1);
        jogo_ativo = 1'b0;
        tick(); chk("drop_req_held1", registra_tiro, 1);
        tick(); chk("drop_req_held2", registra_tiro, 1);
        tiro_registrado = 1'b1;
        tick();
        tiro_registrado = 1'b0;
        chk("drop_db_cd", db_estado, 3);
        chk("drop_tiros_inc", tiros_ativos, m_tiros + 1);
        tick();
        m_tiros = 0;
        chk("drop_db_ini", db_estado, 0);
        chk("drop_tiros_zero", tiros_ativos, 0);
        jogo_ativo = 1'b1;
        tick();
        chk("rejoin_db", db_estado, 1);

        // Asynchronous reset in the middle of a request
        repeat (3) tick();
        botao_tiro = 1'b1;
        n = 0;
        while (!registra_tiro && n < 12) begin tick(); n++; end
        chk("arst_req_seen", registra_tiro, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_registra", registra_tiro, 0);
        chk("arst_db", db_estado, 0);
        chk("arst_pronto", pronto, 0);
        botao_tiro = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick(); tick();
        chk("post_arst_db", db_estado, 1);

        // Held button for 40 cycles with immediate ack
        tiro_registrado = 1'b1;
        botao_tiro = 1'b1;
        prev = 1'b0;
        rises = 0;
        last_rise = 0;
        gap_bad = 0;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (registra_tiro && !prev) begin
                if (rises > 0 && (t - last_rise) != CD + 2) gap_bad++;
                rises++;
                last_rise = t;
            end
            prev = registra_tiro;
        end
        botao_tiro = 1'b0;
        tiro_registrado = 1'b0;
`ifdef DISPARO_AUTO_EN
        chk("hold_rises", rises, MAXT);
        chk("hold_tiros", tiros_ativos, MAXT);
`else
        chk("hold_rises", rises, 1);
        chk("hold_tiros", tiros_ativos, 1);
`endif
        chk("hold_gap", gap_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/controle_disparo.md
# controle_disparo

Upstream stage of the shot-registration path: turns the player's raw fire button into a clean `registra_tiro` request for the shot-registration block and holds it until `tiro_registrado` acknowledges. It synchronises and edge-detects the button, enforces a fire cooldown, and tracks how many shots are on screen so no request is issued beyond the shot-memory capacity. Its `db_estado` output feeds the debug displays like the other control units.

## Interface
- `COOLDOWN_CICLOS`, default 8: minimum cycles spent in COOLDOWN after each acknowledged shot; range 1..255.
- `MAX_TIROS`, default 4: maximum simultaneous shots; range 1..7.
- `clock`  input  1  system clock; all state changes on its rising edge.
- `reset`  input  1  asynchronous, active-low (0 = reset).
- `botao_tiro`  input  1  raw fire button, asynchronous to `clock`.
- `jogo_ativo`  input  1  game running; firing only allowed while high.
- `tiro_registrado`  input  1  acknowledge from the shot-registration block.
- `tiro_liberado`  input  1  one-cycle pulse from downstream: one shot left the screen or was destroyed.
- `registra_tiro`  output  1  level request to the shot-registration block.
- `tiros_ativos`  output  3  shots currently on screen.
- `pronto`  output  1  a new press would be accepted now.
- `db_estado`  output  4  current FSM state code.

## Operation
- Button path: 2-FF synchroniser, then rising-edge detector. One accepted press yields exactly one shot.
- FSM, Moore, codes on `db_estado`:
  - INICIAL=0: `tiros_ativos` forced to 0. Goes to ESPERA when `jogo_ativo`=1.
  - ESPERA=1: on a detected edge with `tiros_ativos` < MAX_TIROS, goes to REGISTRA. `jogo_ativo`=0 returns it to INICIAL.
  - REGISTRA=2: `registra_tiro`=1. On `tiro_registrado`=1, increments `tiros_ativos`, loads the cooldown counter, and goes to COOLDOWN. It never leaves without the ack, even if `jogo_ativo` falls.
  - COOLDOWN=3: decrements the counter; at 0 goes to ESPERA. `jogo_ativo`=0 returns it to INICIAL.
- Any edge detected outside ESPERA, or while `tiros_ativos` = MAX_TIROS, is discarded, not queued.
- `pronto` = (state==ESPERA) and `jogo_ativo` and (`tiros_ativos` < MAX_TIROS).
- `tiros_ativos` rules:
  - Increment on ack; decrement on `tiro_liberado`.
  - Both in the same cycle leave it unchanged.
  - `tiro_liberado` at 0 is ignored; the counter never exceeds MAX_TIROS.
- Cooldown counter width is $clog2(COOLDOWN_CICLOS+1).

## Timing
- Reset values: state INICIAL, `registra_tiro`=0, `tiros_ativos`=0, `pronto`=0, `db_estado`=0, synchroniser flops 0, cooldown counter 0.
- Reset assertion clears everything immediately, without waiting for a clock edge. An open handshake is dropped; the downstream block is reset by the same signal.
- Latency: `botao_tiro` first sampled high at edge k → `registra_tiro` high after edge k+2.
- `registra_tiro` stays high while `tiro_registrado`=0 and falls after the edge that samples the ack. If the ack is already high on the first REGISTRA cycle, the request lasts 1 cycle.
- COOLDOWN lasts exactly COOLDOWN_CICLOS cycles. `pronto` rises on the next cycle.
- Minimum spacing between two request rising edges: COOLDOWN_CICLOS+2 cycles.

## Configuration
- `DISPARO_AUTO_EN` defined: holding `botao_tiro` high acts as autofire. In ESPERA, a synchronised level of 1 is accepted like an edge, so a held button fires once every COOLDOWN_CICLOS+2 cycles, subject to MAX_TIROS.
- Not defined: only rising edges are accepted, so a held button fires once.

## Structure
- Package `disparo_pkg` holds:
  - the state enum with the fixed codes above;
  - the `db_estado` width constant (4);
  - the `tiros_ativos` width constant (3).
- Sub-module `sincroniza_borda` contains the 2-FF synchroniser plus the rising-edge detector. Outputs: synchronised level and one-cycle edge pulse.
- Everything else (FSM, cooldown counter, shot counter) stays in `controle_disparo`.

## Test plan
- Reset release, `jogo_ativo`=1, one 5-cycle button press, ack 2 cycles after the request → `registra_tiro` high 3 cycles (edge k+2 to ack), `tiros_ativos`=1, `db_estado` 1→2→3→1, COOLDOWN exactly 8 cycles.
- Five presses, each after `pronto`=1, with no `tiro_liberado` → four shots registered; fifth press ignored, `pronto`=0, `tiros_ativos`=4. One `tiro_liberado` pulse → `pronto`=1, and the next press registers.
- Press during COOLDOWN → no new request after cooldown ends; `tiros_ativos` unchanged.
- `tiro_liberado` coincident with the ack at `tiros_ativos`=2 → stays 2. `tiro_liberado` at 0 → stays 0.
- `jogo_ativo` dropped in REGISTRA → request held until the ack, then COOLDOWN, then INICIAL with `tiros_ativos`=0. `reset`=0 mid-request → `registra_tiro`=0 immediately, without waiting for a clock edge.
- With `DISPARO_AUTO_EN`, button held 40 cycles, ack immediate → request rising edges 10 cycles apart, up to 4 shots.
